// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in in clk cycles,
// strobes valid_o per completed period and raises an event-counted interrupt.
//
// state | meaning
// IDLE  | capture disabled, counter held
// ARM   | waiting for the first rising edge
// HIGH  | input high, counting
// LOW   | input low, counting; next rise closes the period
// STALL | no edge before counter saturated; waiting for any edge
module pwm_capture #(
  parameter int CNT_WIDTH = 16,
  parameter int EVT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  input  logic                 cap_en,
  input  logic                 int_en,
  input  logic [EVT_WIDTH-1:0] evt_num,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 valid_o,
  output logic                 stall_o,
  output logic                 level_o,
  output logic                 int_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW,
    S_STALL
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 dly_q, dly_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 stall_q, stall_d;
  logic                 int_q, int_d;
  logic [EVT_WIDTH-1:0] evt_q, evt_d;

  logic                 rise;
  logic                 fall;
  logic                 cnt_sat;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Synchronizer, edge detect, measurement FSM and interrupt event counter.
  always_comb begin
    state_d  = state_q;
    sync1_d  = pwm_in;
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    stall_d  = stall_q;
    int_d    = 1'b0;
    evt_d    = evt_q;

    rise    = sync2_q & ~dly_q;
    fall    = ~sync2_q & dly_q;
    cnt_sat = (cnt_q == CNT_MAX);
    // A fall landing exactly on saturation must not wrap the counter.
    cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

    if (!int_en) begin
      evt_d = '0;
    end

    if (!cap_en) begin
      state_d = S_IDLE;
      stall_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
        end
        S_ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            hi_lat_d = cnt_q;
            cnt_d    = cnt_inc;
            state_d  = S_LOW;
          end else if (cnt_sat) begin
            stall_d = 1'b1;
            state_d = S_STALL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_LOW: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hi_lat_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            state_d  = S_HIGH;
            if (int_en) begin
              if (evt_q == evt_num) begin
                int_d = 1'b1;
                evt_d = '0;
              end else begin
                evt_d = evt_q + EVT_WIDTH'(1);
              end
            end
          end else if (cnt_sat) begin
            stall_d = 1'b1;
            state_d = S_STALL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_STALL: begin
          if (rise) begin
            stall_d = 1'b0;
            cnt_d   = CNT_ONE;
            state_d = S_HIGH;
          end else if (fall) begin
            stall_d = 1'b0;
            state_d = S_ARM;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      int_q    <= 1'b0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
      int_q    <= int_d;
      evt_q    <= evt_d;
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign stall_o  = stall_q;
  assign level_o  = sync2_q;
  assign int_o    = int_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_WIDTH=8 so saturation is reachable).
module tb_pwm_capture;

  localparam int CW = 8;
  localparam int EW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pwm_in;
  logic          cap_en;
  logic          int_en;
  logic [EW-1:0] evt_num;
  logic [CW-1:0] period_o;
  logic [CW-1:0] high_o;
  logic          valid_o;
  logic          stall_o;
  logic          level_o;
  logic          int_o;

  int passed = 0;
  int total  = 0;

  // Observation of strobes, sampled 1 ns after each rising edge.
  int          valid_cnt  = 0;
  int          int_cnt    = 0;
  int          int_orphan = 0;
  logic [63:0] int_hist   = '0;
  longint      cyc        = 0;
  longint      last_vcyc  = 0;
  longint      prev_vcyc  = 0;

  pwm_capture #(.CNT_WIDTH(CW), .EVT_WIDTH(EW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .cap_en   (cap_en),
    .int_en   (int_en),
    .evt_num  (evt_num),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .stall_o  (stall_o),
    .level_o  (level_o),
    .int_o    (int_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (valid_o === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      if (int_o === 1'b1) begin
        int_cnt = int_cnt + 1;
        if (valid_cnt < 64) int_hist[valid_cnt] = 1'b1;
      end
    end else if (int_o === 1'b1) begin
      int_orphan = int_orphan + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    pwm_in  = 1'b0;
    cap_en  = 1'b0;
    int_en  = 1'b0;
    evt_num = '0;
    repeat (3) @(negedge clk);

    // 1: reset, then armed with a static low input
    rst_n  = 1'b1;
    cap_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("t1_period", 64'(period_o), 64'd0);
    chk("t1_high",   64'(high_o),   64'd0);
    chk("t1_valid",  64'(valid_o),  64'd0);
    chk("t1_stall",  64'(stall_o),  64'd0);
    chk("t1_level",  64'(level_o),  64'd0);
    chk("t1_int",    64'(int_o),    64'd0);
    chk("t1_vcount", 64'(valid_cnt), 64'd0);

    // 2: steady 30/70, interrupt every period
    int_en = 1'b1;
    pulse(30, 70);
    chk("t2_first_period_no_valid", 64'(valid_cnt), 64'd0);
    repeat (4) pulse(30, 70);
    chk("t2_vcount",   64'(valid_cnt), 64'd4);
    chk("t2_period",   64'(period_o),  64'd100);
    chk("t2_high",     64'(high_o),    64'd30);
    chk("t2_icount",   64'(int_cnt),   64'd4);
    chk("t2_interval", 64'(last_vcyc - prev_vcyc), 64'd100);

    // 3: interrupt on every 4th valid
    evt_num = 3'd3;
    repeat (12) pulse(30, 70);
    chk("t3_vcount", 64'(valid_cnt), 64'd16);
    chk("t3_icount", 64'(int_cnt),   64'd7);
    chk("t3_ihist",  int_hist,       64'h1111E);
    chk("t3_period", 64'(period_o),  64'd100);

    // 4: hold high until the 8-bit counter saturates
    pwm_in = 1'b1;
    repeat (257) @(negedge clk);
    chk("t4_stall_before", 64'(stall_o),   64'd0);
    chk("t4_vcount",       64'(valid_cnt), 64'd17);
    @(negedge clk);
    chk("t4_stall_at_255", 64'(stall_o),   64'd1);
    chk("t4_level",        64'(level_o),   64'd1);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_stall_cleared", 64'(stall_o), 64'd0);
    repeat (40) @(negedge clk);
    pulse(20, 60);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_vcount_after", 64'(valid_cnt), 64'd18);
    chk("t4_period",       64'(period_o),  64'd80);
    chk("t4_high",         64'(high_o),    64'd20);

    // 5: disable during HIGH, edges while disabled are ignored
    repeat (10) @(negedge clk);
    cap_en = 1'b0;
    repeat (3) @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_vcount_off", 64'(valid_cnt), 64'd18);
    chk("t5_period_kept", 64'(period_o), 64'd80);
    chk("t5_high_kept",   64'(high_o),   64'd20);
    cap_en = 1'b1;
    repeat (5) @(negedge clk);
    pulse(25, 35);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_vcount_on", 64'(valid_cnt), 64'd19);
    chk("t5_period",    64'(period_o),  64'd60);
    chk("t5_high",      64'(high_o),    64'd25);

    // 6: minimum pulses H=1/L=1, then reset in LOW
    pwm_in = 1'b0;
    @(negedge clk);
    pwm_in = 1'b1;
    @(negedge clk);
    pwm_in = 1'b0;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_vcount",  64'(valid_cnt), 64'd21);
    chk("t6_period",  64'(period_o),  64'd2);
    chk("t6_high",    64'(high_o),    64'd1);
    chk("t6_ihist",   int_hist,       64'h11111E);
    chk("t6_icount",  64'(int_cnt),   64'd8);
    chk("t6_iorphan", 64'(int_orphan), 64'd0);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_period", 64'(period_o), 64'd0);
    chk("t6_rst_high",   64'(high_o),   64'd0);
    chk("t6_rst_valid",  64'(valid_o),  64'd0);
    chk("t6_rst_stall",  64'(stall_o),  64'd0);
    chk("t6_rst_level",  64'(level_o),  64'd0);
    chk("t6_rst_int",    64'(int_o),    64'd0);
    chk("t6_rst_vcount", 64'(valid_cnt), 64'd21);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
